divider_mem_datapath_block: RTL and testbench

DIVIDER_MEM_DATAPATH_BLOCK -- requirements
Module: divider_mem_datapath

---
 rtl/divider_mem_datapath_block_pkg.sv | 10 +
 rtl/divider_mem_datapath_block_cdf_lane_reg.sv | 33 +++
 rtl/divider_mem_datapath_block.sv | 63 ++++++
 tb/tb_divider_mem_datapath_block.sv | 136 +++++++++++++
 4 files changed

// File: rtl/divider_mem_datapath_block_pkg.sv
// Shared divider configuration: lane width, lanes per memory word and the derived memory word width.
// The divider controller and the datapath both use these values.
package divider_mem_datapath_block_pkg;

    localparam int WORD_W         = 32;
    localparam int LANES_PER_WORD = 4;
    localparam int MEM_W          = WORD_W * LANES_PER_WORD;
    localparam int NUM_DIV_LANES  = 2 * LANES_PER_WORD;

endpackage : divider_mem_datapath_block_pkg

// File: rtl/divider_mem_datapath_block_cdf_lane_reg.sv
// One CDF lane register: a WORD_W-wide register with a synchronous reset and a load enable.
module cdf_lane_reg #(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout
);

    logic [WORD_W-1:0] data_d;
    logic [WORD_W-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is tested first so it wins over load.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign dout = data_q;

endmodule : cdf_lane_reg

// File: rtl/divider_mem_datapath_block.sv
// Splits the two scratch-memory read words into eight CDF lanes and registers them for the dividers.
// The top level only slices and wires; every lane is held in its own cdf_lane_reg.
module divider_mem_datapath_block
    import divider_mem_datapath_block_pkg::*;
#(
    parameter int WORD_W         = divider_mem_datapath_block_pkg::WORD_W,
    parameter int LANES_PER_WORD = divider_mem_datapath_block_pkg::LANES_PER_WORD
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             sc_mem_rd_data_rdy,
    input  logic [WORD_W*LANES_PER_WORD-1:0] sc_mem_rd_data1,
    input  logic [WORD_W*LANES_PER_WORD-1:0] sc_mem_rd_data2,
    output logic [WORD_W-1:0]                cdfval_todiv1,
    output logic [WORD_W-1:0]                cdfval_todiv2,
    output logic [WORD_W-1:0]                cdfval_todiv3,
    output logic [WORD_W-1:0]                cdfval_todiv4,
    output logic [WORD_W-1:0]                cdfval_todiv5,
    output logic [WORD_W-1:0]                cdfval_todiv6,
    output logic [WORD_W-1:0]                cdfval_todiv7,
    output logic [WORD_W-1:0]                cdfval_todiv8
);

    localparam int NUM_LANES = 2 * LANES_PER_WORD;

    logic [WORD_W-1:0] lane_q [NUM_LANES];

    // Capture is qualified by read-data-ready alone; enable is accepted for interface compatibility only.
    logic unused_enable;
    assign unused_enable = enable;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam int SLOT = i % LANES_PER_WORD;
        logic [WORD_W-1:0] lane_din;

        if (i < LANES_PER_WORD) begin : g_word1
            assign lane_din = sc_mem_rd_data1[SLOT*WORD_W +: WORD_W];
        end else begin : g_word2
            assign lane_din = sc_mem_rd_data2[SLOT*WORD_W +: WORD_W];
        end

        cdf_lane_reg #(
            .WORD_W (WORD_W)
        ) u_lane_reg (
            .clk   (clk),
            .reset (reset),
            .load  (sc_mem_rd_data_rdy),
            .din   (lane_din),
            .dout  (lane_q[i])
        );
    end

    assign cdfval_todiv1 = lane_q[0];
    assign cdfval_todiv2 = lane_q[1];
    assign cdfval_todiv3 = lane_q[2];
    assign cdfval_todiv4 = lane_q[3];
    assign cdfval_todiv5 = lane_q[4];
    assign cdfval_todiv6 = lane_q[5];
    assign cdfval_todiv7 = lane_q[6];
    assign cdfval_todiv8 = lane_q[7];

endmodule : divider_mem_datapath_block

// File: tb/tb_divider_mem_datapath_block.sv
// Directed and randomized bench for divider_mem_datapath_block against an array-based reference model.
module tb_divider_mem_datapath_block;

    localparam int W     = 32;
    localparam int LANES = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b0;
    logic         rdy = 1'b0;
    logic [127:0] data1 = '0;
    logic [127:0] data2 = '0;
    logic [W-1:0] todiv [LANES];

    logic [W-1:0] model [LANES];
    bit           model_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    divider_mem_datapath_block dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .sc_mem_rd_data_rdy (rdy),
        .sc_mem_rd_data1    (data1),
        .sc_mem_rd_data2    (data2),
        .cdfval_todiv1      (todiv[0]),
        .cdfval_todiv2      (todiv[1]),
        .cdfval_todiv3      (todiv[2]),
        .cdfval_todiv4      (todiv[3]),
        .cdfval_todiv5      (todiv[4]),
        .cdfval_todiv6      (todiv[5]),
        .cdfval_todiv7      (todiv[6]),
        .cdfval_todiv8      (todiv[7])
    );

    task automatic check(input string tag, input int lane, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s todiv%0d: observed %h expected %h", tag, lane + 1, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < LANES; i++) begin
            check(tag, i, todiv[i], model[i]);
        end
    endtask

    // Reference: a capturing edge loads lane i from word (i / 4), 32-bit field (i % 4); reset clears.
    task automatic model_edge(input logic r, input logic c, input logic [127:0] d1,
                              input logic [127:0] d2);
        logic [127:0] word;
        for (int i = 0; i < LANES; i++) begin
            word = (i < 4) ? d1 : d2;
            if (r) begin
                model[i] = 0;
            end else if (c) begin
                model[i] = W'((word >> (32 * (i % 4))) & 128'hFFFF_FFFF);
            end
        end
    endtask

    // Drive on the falling edge, confirm no combinational path, then check after the rising edge.
    task automatic step(input string tag, input logic r, input logic c, input logic en,
                        input logic [127:0] d1, input logic [127:0] d2);
        @(negedge clk);
        reset  = r;
        rdy    = c;
        enable = en;
        data1  = d1;
        data2  = d2;
        #1;
        if (model_valid) begin
            check_all({tag, "_pre_edge"});
        end
        @(posedge clk);
        model_edge(r, c, d1, d2);
        model_valid = 1'b1;
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [127:0] r1;
        logic [127:0] r2;
        logic         r_rst;
        logic         r_rdy;

        for (int i = 0; i < LANES; i++) model[i] = 0;

        step("reset_with_rdy", 1'b1, 1'b1, 1'b0, 128'd32, 128'd33);
        step("idle_after_reset", 1'b0, 1'b0, 1'b0, 128'd32, 128'd33);
        step("basic_capture", 1'b0, 1'b1, 1'b1, 128'd32, 128'd33);
        step("hold", 1'b0, 1'b0, 1'b1, 128'd64, 128'd65);
        step("hold_again", 1'b0, 1'b0, 1'b0, 128'd64, 128'd65);
        step("recapture", 1'b0, 1'b1, 1'b0, 128'd64, 128'd65);
        step("lane_map", 1'b0, 1'b1, 1'b1,
             128'h00000004_00000003_00000002_00000001,
             128'h00000008_00000007_00000006_00000005);

        r1 = {$urandom, $urandom, $urandom, $urandom};
        r2 = {$urandom, $urandom, $urandom, $urandom};
        step("reset_priority", 1'b1, 1'b1, 1'b1, r1, r2);
        step("capture_after_reset", 1'b0, 1'b1, 1'b0, r1, r2);

        for (int k = 0; k < 4; k++) begin
            r1 = {$urandom, $urandom, $urandom, $urandom};
            r2 = {$urandom, $urandom, $urandom, $urandom};
            step("enable_toggle", 1'b0, 1'b0, k[0], r1, r2);
        end

        for (int k = 0; k < 5; k++) begin
            r1 = {$urandom, $urandom, $urandom, $urandom};
            r2 = {$urandom, $urandom, $urandom, $urandom};
            step("back_to_back", 1'b0, 1'b1, 1'b1, r1, r2);
        end

        for (int k = 0; k < 60; k++) begin
            r1    = {$urandom, $urandom, $urandom, $urandom};
            r2    = {$urandom, $urandom, $urandom, $urandom};
            r_rst = ($urandom_range(0, 9) == 0);
            r_rdy = 1'($urandom_range(0, 1));
            step("random", r_rst, r_rdy, 1'($urandom_range(0, 1)), r1, r2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_divider_mem_datapath_block
